// File: rtl/hazard_stall_controller_if.sv
// Hazard controller bus: pipeline hazard inputs and stall/flush controls.
// master = pipeline side, slave = hazard_stall_controller.
interface hazard_stall_controller_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic             ext_stall_i;
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_use_rs_i;
    logic             id_use_rt_i;
    logic             id_branch_i;
    logic             branch_taken_i;
    logic             idex_mem_read_i;
    logic             idex_reg_write_i;
    logic [REG_W-1:0] idex_rd_i;
    logic             exmem_mem_read_i;
    logic [REG_W-1:0] exmem_rd_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             idex_bubble_o;
    logic             ifid_flush_o;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_count_o;

    modport master (
        output ext_stall_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_branch_i, branch_taken_i, idex_mem_read_i, idex_reg_write_i,
               idex_rd_i, exmem_mem_read_i, exmem_rd_i,
        input  pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, stall_o,
               stall_cycles_o, flush_count_o
    );

    modport slave (
        input  ext_stall_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_branch_i, branch_taken_i, idex_mem_read_i, idex_reg_write_i,
               idex_rd_i, exmem_mem_read_i, exmem_rd_i,
        output pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o, stall_o,
               stall_cycles_o, flush_count_o
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use and ID-branch operand hazards, stall
// sequencing, taken-branch IF/ID flush.
// Optional macro HAZARD_PERF_CNT_EN: enables stall-cycle and flush counters;
// when undefined both counter outputs are tied to zero.
module hazard_stall_controller #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    hazard_stall_controller_if.slave hz
);

    typedef enum logic {
        RUN   = 1'b0,
        HOLD1 = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] need_n;
    logic       rs_valid;
    logic       rt_valid;
    logic       idex_hit;
    logic       exmem_hit;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       stall;

    // Operand matches against EX and MEM destinations; register 0 never hazards
    always_comb begin
        rs_valid  = hz.id_use_rs_i && (hz.id_rs_i != REG_W'(0));
        rt_valid  = hz.id_use_rt_i && (hz.id_rt_i != REG_W'(0));
        idex_hit  = (rs_valid && (hz.id_rs_i == hz.idex_rd_i)) ||
                    (rt_valid && (hz.id_rt_i == hz.idex_rd_i));
        exmem_hit = (rs_valid && (hz.id_rs_i == hz.exmem_rd_i)) ||
                    (rt_valid && (hz.id_rt_i == hz.exmem_rd_i));
    end

    // Required stall count; priority order yields the max over rs/rt
    always_comb begin
        need_n = 2'd0;
        if (hz.id_branch_i && idex_hit && hz.idex_mem_read_i) begin
            need_n = 2'd2;
        end else if (hz.id_branch_i && idex_hit && hz.idex_reg_write_i) begin
            need_n = 2'd1;
        end else if (hz.id_branch_i && exmem_hit && hz.exmem_mem_read_i) begin
            need_n = 2'd1;
        end else if (!hz.id_branch_i && idex_hit && hz.idex_mem_read_i) begin
            need_n = 2'd1;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pipeline controls; reset, then external freeze, dominate
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        stall       = 1'b0;
        if (rst_i) begin
            state_d = RUN;
        end else if (hz.ext_stall_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (need_n != 2'd0) begin
                        stall = 1'b1;
                    end
                    if (need_n == 2'd2) begin
                        state_d = HOLD1;
                    end
                end
                HOLD1: begin
                    stall   = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
            if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            ifid_flush = hz.branch_taken_i && hz.id_branch_i && !stall;
        end
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.ifid_write_o  = ifid_write;
    assign hz.idex_bubble_o = idex_bubble;
    assign hz.ifid_flush_o  = ifid_flush;
    assign hz.stall_o       = stall;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (ifid_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cycles_o = stall_cnt_q;
    assign hz.flush_count_o  = flush_cnt_q;
`else
    assign hz.stall_cycles_o = CNT_W'(0);
    assign hz.flush_count_o  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller.
module tb_hazard_stall_controller;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_write, ifid_write, idex_bubble, ifid_flush, stall}
    localparam logic [4:0] V_RUN    = 5'b11000;
    localparam logic [4:0] V_STALL  = 5'b00101;
    localparam logic [4:0] V_FLUSH  = 5'b11010;
    localparam logic [4:0] V_FROZEN = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nerr = 0;

    hazard_stall_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    hazard_stall_controller #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    wire [4:0] outs = {hz.pc_write_o, hz.ifid_write_o, hz.idex_bubble_o,
                       hz.ifid_flush_o, hz.stall_o};

    function automatic logic [CNT_W-1:0] cexp(input int unsigned v);
        return PERF ? CNT_W'(v) : CNT_W'(0);
    endfunction

    task automatic clear_in();
        hz.ext_stall_i      = 1'b0;
        hz.id_rs_i          = '0;
        hz.id_rt_i          = '0;
        hz.id_use_rs_i      = 1'b0;
        hz.id_use_rt_i      = 1'b0;
        hz.id_branch_i      = 1'b0;
        hz.branch_taken_i   = 1'b0;
        hz.idex_mem_read_i  = 1'b0;
        hz.idex_reg_write_i = 1'b0;
        hz.idex_rd_i        = '0;
        hz.exmem_mem_read_i = 1'b0;
        hz.exmem_rd_i       = '0;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd7;
        hz.id_rs_i = 5'd7; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL reset_outputs_during: got %b want %b", outs, V_RUN);
        end
        tick();
        rst = 1'b0;
        clear_in();
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL reset_outputs_after: got %b want %b", outs, V_RUN);
        end
        nchk++;
        if (hz.stall_cycles_o !== CNT_W'(0) || hz.flush_count_o !== CNT_W'(0)) begin
            nerr++; $display("FAIL reset_counters: got %0d/%0d want 0/0",
                             hz.stall_cycles_o, hz.flush_count_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd2;
        hz.id_rs_i = 5'd2; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL load_use_stall: got %b want %b", outs, V_STALL);
        end
        tick();
        clear_in();
        hz.exmem_mem_read_i = 1'b1; hz.exmem_rd_i = 5'd2;
        hz.id_rs_i = 5'd2; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL load_use_resolved: got %b want %b", outs, V_RUN);
        end
        nchk++;
        if (hz.stall_cycles_o !== cexp(1)) begin
            nerr++; $display("FAIL load_use_count: got %0d want %0d",
                             hz.stall_cycles_o, cexp(1));
        end
        // rt operand hazard
        clear_in();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd9;
        hz.id_rt_i = 5'd9; hz.id_use_rt_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL load_use_rt: got %b want %b", outs, V_STALL);
        end
        // same index but operand not read
        hz.id_use_rt_i = 1'b0;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL load_use_unused_operand: got %b want %b", outs, V_RUN);
        end
        clear_in();
    endtask

    task automatic test_branch_load();
        apply_reset();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd3;
        hz.id_branch_i = 1'b1; hz.id_rt_i = 5'd3; hz.id_use_rt_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL br_load_stall1: got %b want %b", outs, V_STALL);
        end
        tick();
        // HOLD1: lw now in MEM; inputs must be ignored, including a taken branch
        clear_in();
        hz.exmem_mem_read_i = 1'b1; hz.exmem_rd_i = 5'd3;
        hz.id_branch_i = 1'b1; hz.branch_taken_i = 1'b1;
        hz.id_rt_i = 5'd3; hz.id_use_rt_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL br_load_stall2: got %b want %b", outs, V_STALL);
        end
        tick();
        clear_in();
        hz.id_branch_i = 1'b1; hz.id_rt_i = 5'd3; hz.id_use_rt_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL br_load_resume: got %b want %b", outs, V_RUN);
        end
        nchk++;
        if (hz.stall_cycles_o !== cexp(2)) begin
            nerr++; $display("FAIL br_load_count: got %0d want %0d",
                             hz.stall_cycles_o, cexp(2));
        end
        clear_in();
    endtask

    task automatic test_branch_alu_flush();
        apply_reset();
        hz.idex_reg_write_i = 1'b1; hz.idex_rd_i = 5'd4;
        hz.id_branch_i = 1'b1; hz.branch_taken_i = 1'b1;
        hz.id_rs_i = 5'd4; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL br_alu_stall: got %b want %b", outs, V_STALL);
        end
        tick();
        clear_in();
        hz.id_branch_i = 1'b1; hz.branch_taken_i = 1'b1;
        hz.id_rs_i = 5'd4; hz.id_use_rs_i = 1'b1;
        hz.exmem_rd_i = 5'd4;
        #1;
        nchk++;
        if (outs !== V_FLUSH) begin
            nerr++; $display("FAIL br_alu_flush: got %b want %b", outs, V_FLUSH);
        end
        tick();
        clear_in();
        #1;
        nchk++;
        if (hz.flush_count_o !== cexp(1) || hz.stall_cycles_o !== cexp(1)) begin
            nerr++; $display("FAIL br_alu_counts: got %0d/%0d want %0d/%0d",
                             hz.stall_cycles_o, hz.flush_count_o, cexp(1), cexp(1));
        end
        // branch operand produced by a load now in MEM
        hz.exmem_mem_read_i = 1'b1; hz.exmem_rd_i = 5'd5;
        hz.id_branch_i = 1'b1; hz.id_rs_i = 5'd5; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL br_mem_load_stall: got %b want %b", outs, V_STALL);
        end
        tick();
        // rs hits MEM load (1) while rt hits EX load (2): max wins -> two stalls
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd6;
        hz.id_rt_i = 5'd6; hz.id_use_rt_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL br_max_first: got %b want %b", outs, V_STALL);
        end
        tick();
        clear_in();
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL br_max_hold: got %b want %b", outs, V_STALL);
        end
        tick();
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL br_max_resume: got %b want %b", outs, V_RUN);
        end
    endtask

    task automatic test_reg_zero();
        apply_reset();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd0;
        hz.id_rs_i = 5'd0; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL reg_zero_load: got %b want %b", outs, V_RUN);
        end
        hz.id_branch_i = 1'b1;
        hz.id_rt_i = 5'd0; hz.id_use_rt_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL reg_zero_branch: got %b want %b", outs, V_RUN);
        end
        clear_in();
    endtask

    task automatic test_ext_stall();
        apply_reset();
        // freeze in RUN suppresses a taken-branch flush
        hz.ext_stall_i = 1'b1;
        hz.id_branch_i = 1'b1; hz.branch_taken_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_FROZEN) begin
            nerr++; $display("FAIL ext_no_flush: got %b want %b", outs, V_FROZEN);
        end
        clear_in();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd8;
        hz.id_branch_i = 1'b1; hz.id_rs_i = 5'd8; hz.id_use_rs_i = 1'b1;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL ext_enter: got %b want %b", outs, V_STALL);
        end
        tick();
        clear_in();
        hz.ext_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nchk++;
            if (outs !== V_FROZEN) begin
                nerr++; $display("FAIL ext_frozen[%0d]: got %b want %b", i, outs, V_FROZEN);
            end
            tick();
        end
        nchk++;
        if (hz.stall_cycles_o !== cexp(1)) begin
            nerr++; $display("FAIL ext_count_held: got %0d want %0d",
                             hz.stall_cycles_o, cexp(1));
        end
        hz.ext_stall_i = 1'b0;
        #1;
        nchk++;
        if (outs !== V_STALL) begin
            nerr++; $display("FAIL ext_release_hold: got %b want %b", outs, V_STALL);
        end
        tick();
        #1;
        nchk++;
        if (outs !== V_RUN || hz.stall_cycles_o !== cexp(2)) begin
            nerr++; $display("FAIL ext_resume: got %b/%0d want %b/%0d",
                             outs, hz.stall_cycles_o, V_RUN, cexp(2));
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        hz.idex_mem_read_i = 1'b1; hz.idex_rd_i = 5'd3;
        hz.id_branch_i = 1'b1; hz.id_rs_i = 5'd3; hz.id_use_rs_i = 1'b1;
        tick();
        clear_in();
        rst = 1'b1;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL rst_hold_during: got %b want %b", outs, V_RUN);
        end
        tick();
        rst = 1'b0;
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL rst_hold_after: got %b want %b", outs, V_RUN);
        end
        nchk++;
        if (hz.stall_cycles_o !== CNT_W'(0) || hz.flush_count_o !== CNT_W'(0)) begin
            nerr++; $display("FAIL rst_hold_counters: got %0d/%0d want 0/0",
                             hz.stall_cycles_o, hz.flush_count_o);
        end
        tick();
        #1;
        nchk++;
        if (outs !== V_RUN) begin
            nerr++; $display("FAIL rst_hold_no_residual: got %b want %b", outs, V_RUN);
        end
    endtask

    initial begin
        clear_in();
        #2;
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu_flush();
        test_reg_zero();
        test_ext_stall();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
